// File: rtl/mouse_pos_tracker.sv
// +-----------------------------------------------------------------------------+
// | mouse_pos_tracker : PS/2 3-byte packet assembler and clamped position      |
// | integrator. Optional macro MOUSE_ACCEL_EN doubles deltas with |d| >= 8.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mouse_pos_tracker #(
  parameter int H_MAX          = 799,
  parameter int V_MAX          = 599,
  parameter int X_INIT         = 400,
  parameter int Y_INIT         = 300,
  parameter int TIMEOUT_CYCLES = 80000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] mouse_x_position,
  output logic [11:0] mouse_y_position,
  output logic        mouse_left,
  output logic        mouse_right,
  output logic        mouse_middle,
  output logic        packet_valid
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] WAIT_B0 = 2'd0;
  localparam logic [1:0] WAIT_B1 = 2'd1;
  localparam logic [1:0] WAIT_B2 = 2'd2;

  localparam logic signed [13:0] C_H_MAX = 14'(H_MAX);
  localparam logic signed [13:0] C_V_MAX = 14'(V_MAX);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  // byte0 minus the always-1 sync bit: {yovf, xovf, ysign, xsign, M, R, L}
  logic [6:0]    r_b0;
  logic [7:0]    r_b1;
  logic [11:0]   r_x;
  logic [11:0]   r_y;
  logic          r_left;
  logic          r_right;
  logic          r_middle;
  logic          r_pv;

  logic signed [13:0] w_dx;
  logic signed [13:0] w_dy;
  logic signed [13:0] w_xsum;
  logic signed [13:0] w_ysum;
  logic               w_timeout;

  function automatic logic signed [13:0] axis_delta(input logic sign,
                                                    input logic [7:0] mag,
                                                    input logic ovf);
    logic signed [13:0] d;
    d = ovf ? 14'sd0 : $signed({{6{sign}}, mag});
`ifdef MOUSE_ACCEL_EN
    if (d >= 14'sd8 || d <= -14'sd8) d = d <<< 1;
`endif
    return d;
  endfunction

  function automatic logic [11:0] clamp(input logic signed [13:0] v,
                                        input logic signed [13:0] max);
    if (v < 14'sd0)     return 12'd0;
    else if (v > max)   return max[11:0];
    else                return v[11:0];
  endfunction

  assign w_dx      = axis_delta(r_b0[3], r_b1,    r_b0[5]);
  assign w_dy      = axis_delta(r_b0[4], rx_data, r_b0[6]);
  assign w_xsum    = $signed({2'b00, r_x}) + w_dx;
  // PS/2 positive Y is upward, screen Y grows downward
  assign w_ysum    = $signed({2'b00, r_y}) - w_dy;
  assign w_timeout = !rx_valid && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= WAIT_B0;
      r_cnt    <= '0;
      r_b0     <= '0;
      r_b1     <= '0;
      r_x      <= 12'(X_INIT);
      r_y      <= 12'(Y_INIT);
      r_left   <= 1'b0;
      r_right  <= 1'b0;
      r_middle <= 1'b0;
      r_pv     <= 1'b0;
    end else begin
      r_pv <= 1'b0;
      case (r_state)
        WAIT_B0: begin
          r_cnt <= '0;
          if (rx_valid && rx_data[3]) begin
            r_b0    <= {rx_data[7:4], rx_data[2:0]};
            r_state <= WAIT_B1;
          end
        end
        WAIT_B1: begin
          if (rx_valid) begin
            r_b1    <= rx_data;
            r_cnt   <= '0;
            r_state <= WAIT_B2;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_state <= WAIT_B0;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        WAIT_B2: begin
          if (rx_valid) begin
            r_x      <= clamp(w_xsum, C_H_MAX);
            r_y      <= clamp(w_ysum, C_V_MAX);
            r_left   <= r_b0[0];
            r_right  <= r_b0[1];
            r_middle <= r_b0[2];
            r_pv     <= 1'b1;
            r_cnt    <= '0;
            r_state  <= WAIT_B0;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_state <= WAIT_B0;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= WAIT_B0;
        end
      endcase
    end
  end

  assign mouse_x_position = r_x;
  assign mouse_y_position = r_y;
  assign mouse_left       = r_left;
  assign mouse_right      = r_right;
  assign mouse_middle     = r_middle;
  assign packet_valid     = r_pv;

endmodule

`default_nettype wire
